// File: rtl/nf2_ts_stamper.sv
// In-band timestamp stamper: overwrites a chosen payload word of enabled-port packets with the SOP cycle count.
// Latency: 1 cycle from accept to out_wr when the FIFO is empty and out_rdy is high; 1 word/cycle sustained.
// Backpressure: FIFO_DEPTH-entry buffer; in_rdy drops when full and rises the cycle after a pop frees a slot.
module nf2_ts_stamper #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int TS_WIDTH   = 64,
    parameter int NUM_PORTS  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    input  logic [NUM_PORTS-1:0]  stamp_en,
    input  logic [7:0]            ts_word_offset,
    input  logic                  count_clear,
    output logic [TS_WIDTH-1:0]   ts_now,
    output logic [31:0]           stamped_count,
    output logic [31:0]           missed_count
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int WW = DATA_WIDTH + CTRL_WIDTH;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;

    state_t                r_state, w_state_nxt;
    logic [8:0]            r_idx, w_idx_nxt, w_word_idx;
    logic                  r_elig, w_elig_nxt;
    logic                  r_stamped, w_stamped_nxt;
    logic [TS_WIDTH-1:0]   r_ts_now, r_ts_cap;
    logic [31:0]           r_stamped_count, r_missed_count;

    logic [WW-1:0]         r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
    logic [AW:0]           r_count;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [CTRL_WIDTH-1:0] r_out_ctrl;
    logic                  r_out_wr;

    logic                  w_push, w_pop, w_empty, w_bypass, w_fifo_wr;
    logic                  w_is_hdr, w_is_zero, w_src_ok, w_en_sel;
    logic [15:0]           w_src;
    logic [14:0]           w_port;
    logic                  w_cap, w_stamp, w_inc_stamped, w_inc_missed;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [WW-1:0]         w_in_word, w_head;

    assign in_rdy        = (r_count < DEPTH_C);
    assign w_push        = in_wr && in_rdy;
    assign w_empty       = (r_count == '0);
    assign w_pop         = !w_empty && out_rdy;
    assign w_bypass      = w_empty && w_push && out_rdy;
    assign w_fifo_wr     = w_push && !w_bypass;

    assign w_is_hdr      = (in_ctrl == {CTRL_WIDTH{1'b1}});
    assign w_is_zero     = (in_ctrl == '0);
    assign w_src         = in_data[31:16];
    assign w_port        = w_src[15:1];

    // Out-of-range ports simply never match, so they read as disabled.
    always_comb begin
        w_en_sel = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_port == p[14:0]) w_en_sel = stamp_en[p];
        end
    end
    assign w_src_ok = !w_src[0] && w_en_sel;

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_elig_nxt    = r_elig;
        w_stamped_nxt = r_stamped;
        w_word_idx    = r_idx;
        w_cap         = 1'b0;
        w_stamp       = 1'b0;
        w_inc_stamped = 1'b0;
        w_inc_missed  = 1'b0;
        if (w_push) begin
            case (r_state)
                S_IDLE: begin
                    w_cap         = 1'b1;
                    w_stamped_nxt = 1'b0;
                    w_elig_nxt    = 1'b0;
                    if (w_is_hdr) begin
                        w_elig_nxt  = w_src_ok;
                        w_state_nxt = S_HDR;
                    end else begin
                        w_idx_nxt   = 9'd1;
                        w_state_nxt = w_is_zero ? S_DATA : S_IDLE;
                    end
                end
                S_HDR: begin
                    if (w_is_zero) begin
                        w_word_idx    = 9'd0;
                        w_idx_nxt     = 9'd1;
                        w_stamp       = r_elig && (ts_word_offset == 8'd0);
                        w_stamped_nxt = w_stamp;
                        w_state_nxt   = S_DATA;
                    end else if (!w_is_hdr) begin
                        w_inc_missed  = r_elig;
                        w_state_nxt   = S_IDLE;
                    end
                end
                S_DATA: begin
                    // Index saturates at 511, which no 8-bit offset can match.
                    if (r_idx != '1) w_idx_nxt = r_idx + 9'd1;
                    w_stamp       = r_elig && w_is_zero && (w_word_idx == {1'b0, ts_word_offset});
                    w_stamped_nxt = r_stamped || w_stamp;
                    if (!w_is_zero) begin
                        w_inc_stamped = r_stamped;
                        w_inc_missed  = r_elig && !r_stamped;
                        w_state_nxt   = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign w_wr_data = w_stamp ? DATA_WIDTH'(r_ts_cap) : in_data;
    assign w_in_word = {w_wr_data, in_ctrl};
    assign w_head    = w_empty ? w_in_word : r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_ts_now <= '0;
        else        r_ts_now <= r_ts_now + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_elig    <= 1'b0;
            r_stamped <= 1'b0;
            r_ts_cap  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_elig    <= w_elig_nxt;
            r_stamped <= w_stamped_nxt;
            if (w_cap) r_ts_cap <= r_ts_now;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stamped_count <= '0;
            r_missed_count  <= '0;
        end else if (count_clear) begin
            r_stamped_count <= '0;
            r_missed_count  <= '0;
        end else begin
            if (w_inc_stamped && (r_stamped_count != '1)) r_stamped_count <= r_stamped_count + 32'd1;
            if (w_inc_missed && (r_missed_count != '1))   r_missed_count  <= r_missed_count + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_fifo_wr) r_mem[r_wr_ptr] <= w_in_word;
    end

    // An empty FIFO forwards the incoming word straight into the output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_out_data <= '0;
            r_out_ctrl <= '0;
            r_out_wr   <= 1'b0;
        end else begin
            if (w_fifo_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_fifo_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_pop || w_bypass) begin
                r_out_data <= w_head[WW-1:CTRL_WIDTH];
                r_out_ctrl <= w_head[CTRL_WIDTH-1:0];
                r_out_wr   <= 1'b1;
            end else begin
                r_out_wr   <= 1'b0;
            end
        end
    end

    assign out_data      = r_out_data;
    assign out_ctrl      = r_out_ctrl;
    assign out_wr        = r_out_wr;
    assign ts_now        = r_ts_now;
    assign stamped_count = r_stamped_count;
    assign missed_count  = r_missed_count;

endmodule

// File: tb/tb_nf2_ts_stamper.sv
// Directed bench for nf2_ts_stamper: stimulus pushes expected words, an independent monitor pops and compares.
module tb_nf2_ts_stamper;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        in_wr;
    logic        in_rdy;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr;
    logic        out_rdy;
    logic [3:0]  stamp_en;
    logic [7:0]  ts_word_offset;
    logic        count_clear;
    logic [63:0] ts_now;
    logic [31:0] stamped_count;
    logic [31:0] missed_count;

    logic [71:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nf2_ts_stamper #(
        .DATA_WIDTH(64), .CTRL_WIDTH(8), .TS_WIDTH(64), .NUM_PORTS(4), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
        .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
        .stamp_en(stamp_en), .ts_word_offset(ts_word_offset), .count_clear(count_clear),
        .ts_now(ts_now), .stamped_count(stamped_count), .missed_count(missed_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (reset && out_wr) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out actual=%h/%h required=none", out_data, out_ctrl);
            end else begin
                logic [71:0] e;
                e = exp_q.pop_front();
                chk("out_data", out_data, e[71:8]);
                chk("out_ctrl", {56'h0, out_ctrl}, {56'h0, e[7:0]});
            end
        end
    end

    function automatic logic [63:0] hw(input logic [15:0] src);
        return {32'h1234_5678, src, 16'h0040};
    endfunction

    function automatic logic [63:0] dw(input logic [7:0] tag, input int i);
        return {8'hDD, tag, 40'h0, i[7:0]};
    endfunction

    task automatic send_word(input logic [63:0] d, input logic [7:0] c, input logic [63:0] ed);
        int n;
        n = 0;
        @(negedge clk);
        in_wr = 1'b0;
        while (!in_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_rdy) begin
            checks++;
            errors++;
            $display("FAIL in_rdy_timeout actual=0 required=1");
        end else begin
            in_data = d;
            in_ctrl = c;
            in_wr   = 1'b1;
            exp_q.push_back({ed, c});
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_wr = 1'b0;
    endtask

    task automatic send_pkt(input logic [15:0] src, input int nd, input int stamp_at,
                            input logic [63:0] tsv, input logic [7:0] tag);
        logic [7:0] c;
        send_word(hw(src), 8'hFF, hw(src));
        for (int i = 0; i < nd; i++) begin
            c = (i == nd - 1) ? 8'h01 : 8'h00;
            send_word(dw(tag, i), c, (i == stamp_at) ? tsv : dw(tag, i));
        end
        idle();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        reset = 1'b0; in_wr = 1'b0; in_data = '0; in_ctrl = '0; out_rdy = 1'b1;
        stamp_en = 4'b0001; ts_word_offset = 8'd2; count_clear = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_wr", out_wr, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ctrl", out_ctrl, 0);
        chk("rst_ts_now", ts_now, 0);
        chk("rst_stamped", stamped_count, 0);
        chk("rst_missed", missed_count, 0);
        chk("rst_in_rdy", in_rdy, 1);
        @(negedge clk);
        reset = 1'b1;

        // Header accepted at the 17th edge after release, when ts_now reads 0x10.
        repeat (16) @(posedge clk);
        send_pkt(16'd0, 5, 2, 64'h10, 8'h01);
        repeat (4) @(negedge clk);
        #1;
        chk("t1_stamped", stamped_count, 1);
        chk("t1_missed", missed_count, 0);

        @(negedge clk); count_clear = 1'b1;
        @(negedge clk); count_clear = 1'b0;
        #1;
        chk("clr_stamped", stamped_count, 0);
        chk("clr_missed", missed_count, 0);

        send_pkt(16'd2, 3, -1, 64'h0, 8'h02);
        send_pkt(16'd1, 3, -1, 64'h0, 8'h03);
        repeat (4) @(negedge clk);
        #1;
        chk("t2_stamped", stamped_count, 0);
        chk("t2_missed", missed_count, 0);

        ts_word_offset = 8'd5;
        send_pkt(16'd0, 3, -1, 64'h0, 8'h04);
        ts_word_offset = 8'd2;
        send_pkt(16'd0, 3, -1, 64'h0, 8'h05);
        repeat (4) @(negedge clk);
        #1;
        chk("t3_stamped", stamped_count, 0);
        chk("t3_missed", missed_count, 2);

        out_rdy = 1'b0;
        fork
            send_pkt(16'd1, 5, -1, 64'h0, 8'h06);
            begin
                repeat (12) @(negedge clk);
                #1;
                chk("bp_accepted", exp_q.size(), 4);
                chk("bp_in_rdy", in_rdy, 0);
                chk("bp_out_wr", out_wr, 0);
                out_rdy = 1'b1;
                for (int k = 0; k < 6; k++) begin
                    @(negedge clk);
                    #1;
                    chk("bp_drain_wr", out_wr, 1);
                end
            end
        join
        repeat (3) @(negedge clk);

        ts_word_offset = 8'd0;
        @(negedge clk);
        force dut.r_stamped_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_stamped_count;
        chk("sat_preload", stamped_count, 32'hFFFF_FFFF);
        force dut.r_ts_now = 64'hFFFF_FFFF_FFFF_FFFF;
        send_word(hw(16'd0), 8'hFF, hw(16'd0));
        send_word(dw(8'h07, 0), 8'h00, 64'hFFFF_FFFF_FFFF_FFFF);
        release dut.r_ts_now;
        send_word(dw(8'h07, 1), 8'h01, dw(8'h07, 1));
        idle();
        repeat (3) @(negedge clk);
        #1;
        chk("sat_stamped", stamped_count, 32'hFFFF_FFFF);
        chk("sat_missed", missed_count, 2);

        ts_word_offset = 8'd5;
        send_word(hw(16'd0), 8'hFF, hw(16'd0));
        send_word(dw(8'h08, 0), 8'h00, dw(8'h08, 0));
        send_word(dw(8'h08, 1), 8'h01, dw(8'h08, 1));
        count_clear = 1'b1;
        idle();
        count_clear = 1'b0;
        #1;
        chk("clr_eop_stamped", stamped_count, 0);
        chk("clr_eop_missed", missed_count, 0);
        repeat (3) @(negedge clk);

        ts_word_offset = 8'd1;
        send_word(hw(16'd0), 8'hFF, hw(16'd0));
        send_word(dw(8'h09, 0), 8'h00, dw(8'h09, 0));
        @(negedge clk);
        in_wr = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_out_wr", out_wr, 0);
        chk("mid_rst_in_rdy", in_rdy, 1);
        chk("mid_rst_ts_now", ts_now, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        // Header accepted at the 6th edge after release, when ts_now reads 5.
        repeat (5) @(posedge clk);
        send_pkt(16'd0, 4, 1, 64'h5, 8'h0A);
        repeat (4) @(negedge clk);
        #1;
        chk("post_rst_stamped", stamped_count, 1);
        chk("post_rst_missed", missed_count, 0);

        repeat (5) @(negedge clk);
        chk("drain_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nf2_ts_stamper.md
# nf2_ts_stamper

Parametrised in-band timestamp stamper for the rtt_probe data path. It sits on the 64-bit NetFPGA packet bus between the output queues and a MAC group's TX queue. It captures a free-running cycle timestamp when a packet's first word is accepted. For packets whose IOQ source port is enabled, it overwrites a programmable payload word with that timestamp. It supports NUM_PORTS MAC ports, has an internal FIFO for backpressure, and provides saturating statistics counters.

## Interface
- DATA_WIDTH, 64, bus data width
- CTRL_WIDTH, DATA_WIDTH/8, bus ctrl width
- TS_WIDTH, 64, timestamp width; must be ≤ DATA_WIDTH
- NUM_PORTS, 4, number of MAC ports eligible for stamping
- FIFO_DEPTH, 4, internal buffer depth; power of two, ≥ 2
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- in_data  in  DATA_WIDTH  upstream word
- in_ctrl  in  CTRL_WIDTH  upstream ctrl
- in_wr  in  1  upstream write strobe
- in_rdy  out  1  block can accept a word this cycle
- out_data  out  DATA_WIDTH  downstream word
- out_ctrl  out  CTRL_WIDTH  downstream ctrl
- out_wr  out  1  downstream write strobe
- out_rdy  in  1  downstream can accept
- stamp_en  in  NUM_PORTS  per-MAC-port stamping enable
- ts_word_offset  in  8  index of the data word to overwrite (0 = first word with ctrl==0)
- count_clear  in  1  synchronous clear of statistics
- ts_now  out  TS_WIDTH  free-running timestamp
- stamped_count  out  32  packets stamped
- missed_count  out  32  enabled packets that ended before reaching the offset word

## Operation
- **Timestamp counter.** ts_now increments by 1 every clk and wraps from all-ones to 0.
- **Parser states.**
  - IDLE: the next accepted word is the first word of a packet.
    - Capture ts_cap = ts_now.
    - Go to HDR if ctrl==0xFF, otherwise go to DATA with word index 0.
  - HDR: module header words (ctrl==0xFF).
    - The IOQ header is the header word whose data[31:16] is the source port.
    - Eligible iff src is even and src>>1 < NUM_PORTS and stamp_en[src>>1]==1.
    - The first accepted word with ctrl==0 moves the parser to DATA with index 0.
  - DATA: each accepted word increments the index.
    - A word with ctrl≠0 is the last word: return to IDLE.
- **Stamping.**
  - Condition: eligible, in DATA, index == ts_word_offset, and ctrl==0.
  - Action: the word is stored as {zeros, ts_cap[TS_WIDTH-1:0]}; ctrl is unchanged.
  - The last word is never stamped.
- **End-of-packet statistics.**
  - stamped_count += 1 if the packet was stamped.
  - missed_count += 1 if the packet was eligible but not stamped.
  - Both counters saturate at 0xFFFFFFFF.
  - count_clear overrides a simultaneous increment; the result is 0.
- **Input/output paths.**
  - Words pass through the FIFO in order. Non-stamped words are passed unchanged.
  - in_rdy = (occupancy < FIFO_DEPTH), combinational from registered occupancy.
  - Upstream asserts in_wr only while in_rdy==1. in_wr while in_rdy==0 is ignored and the parser does not advance.
- **Configuration sampling.** stamp_en is sampled on the IOQ header word. ts_word_offset is sampled on each DATA word. Changes mid-packet affect only later samples.

## Timing
- **Reset values.**
  - out_wr=0, out_data=0, out_ctrl=0.
  - ts_now=0, stamped_count=0, missed_count=0.
  - FIFO empty, parser IDLE, so in_rdy=1 while in reset and after it.
- **Latency.**
  - Output registers load the FIFO head when out_rdy==1 and the FIFO is non-empty; otherwise out_wr=0 that cycle.
  - A word written at cycle t into an empty FIFO with out_rdy==1 appears with out_wr=1 at t+1.
  - Sustained throughput is 1 word/cycle.
- **Simultaneous push/pop.**
  - At any occupancy, occupancy is unchanged.
  - When full, no push occurs (in_rdy==0). A pop frees a slot, and in_rdy rises the next cycle.
- **Timestamp value.** ts_cap equals the ts_now value during the cycle the first word is accepted, wrap included.
- **Statistics timing.** Counters update the cycle after the last word is accepted.
- **Reset mid-packet.** The FIFO is flushed, the parser returns to IDLE, and partial packets are dropped. The first word after release is treated as a packet start.

## Test plan
- **Stamp on enabled port.**
  - Stimulus: reset, stamp_en=4'b0001, offset=2; packet with one 0xFF header (src=0) then 5 data words, last ctrl=0x01; first word accepted when ts_now=0x10.
  - Required: data word 2 out = 0x0000000000000010; other words unchanged; stamped_count=1.
- **Disabled and CPU ports.**
  - Stimulus: src=2 with stamp_en[1]=0, and src=1.
  - Required: both packets pass bit-exact; both counters stay 0.
- **Offset beyond packet.**
  - Stimulus: offset=5 on a 3-data-word eligible packet; then offset=2 where word 2 is the last word.
  - Required: no word modified; missed_count=2.
- **Backpressure.**
  - Stimulus: out_rdy=0 for 10 cycles with continuous in_wr while in_rdy==1.
  - Required: exactly 4 words accepted; in_rdy=0; out_wr=0. After out_rdy=1, words exit in order, one per cycle, starting the next cycle.
- **Wrap and saturation.**
  - Stimulus: force ts_now near all-ones so the capture is 0xFFFF_FFFF_FFFF_FFFF; preload stamped_count=0xFFFFFFFF; then count_clear concurrent with an end-of-packet.
  - Required: stamped word = all-ones; stamped_count stays 0xFFFFFFFF; after the clear it reads 0.
- **Reset mid-packet.**
  - Stimulus: assert reset after 2 of 6 words.
  - Required: out_wr=0 and in_rdy=1 immediately. The next packet is stamped correctly with a fresh ts_cap.
